mem_lsu: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline, consuming the registered outputs of the EX/MEM pipeline register and feeding the MEM/WB register. ALU, HI/LO and register-write results pass straight through for non-memory ops. Loads and stores run a handshaked transaction on the data bus, with byte-lane selection and sign/zero extension of load data. The stage raises `stallreq` to freeze the pipeline until the access completes, errors, or times out.

---
 rtl/mem_lsu_pkg.sv | 57 +++++
 rtl/mem_lsu_if.sv | 20 ++
 rtl/mem_lane_ext.sv | 37 +++
 rtl/mem_lsu.sv | 156 +++++++++++++++
 tb/tb_mem_lsu.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM stage: load/store opcodes, FSM states,
// pipeline constants and small lane/alignment decoders.
package mem_lsu_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr = 5'b00000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_t;

    function automatic logic is_mem_op(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                          EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return a[0];
            EXE_LW_OP, EXE_SW_OP:             return a != 2'b00;
            default:                          return 1'b0;
        endcase
    endfunction

    // Big-endian: byte offset 0 lives in bits [31:24], hence lane 3 of bus_sel.
    function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] a);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 4'b1000 >> a;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return a[1] ? 4'b0011 : 4'b1100;
            default:                          return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] d);
        case (op)
            EXE_SB_OP: return {4{d[7:0]}};
            EXE_SH_OP: return {2{d[15:0]}};
            default:   return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus handshake between the MEM stage (master) and the memory system (slave).
interface mem_lsu_if;
    logic        bus_ce;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_ce, bus_we, bus_addr, bus_sel, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_ce, bus_we, bus_addr, bus_sel, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_lane_ext.sv
// Picks the addressed byte/half out of a big-endian load word and sign- or
// zero-extends it according to the load opcode.
module mem_lane_ext
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] ext
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = word[31 - 8*gi -: 8];
        end
    endgenerate

    assign byte_v = lanes[addr];
    assign half_v = addr[1] ? word[15:0] : word[31:16];

    always_comb begin
        ext = word;
        case (aluop)
            EXE_LB_OP:  ext = {{24{byte_v[7]}}, byte_v};
            EXE_LBU_OP: ext = {24'h0, byte_v};
            EXE_LH_OP:  ext = {{16{half_v[15]}}, half_v};
            EXE_LHU_OP: ext = {16'h0, half_v};
            default:    ext = word;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MIPS MEM stage: passes ALU/HI/LO results through and runs load/store
// transactions on the data bus, stalling the pipeline until they finish.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        whilo_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o,
    output logic        stallreq,
    output logic        exc_align,
    output logic        exc_bus,
    mem_lsu_if.master   bus
);

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

    lsu_state_t  state_reg;
    logic [7:0]  cnt_reg;
    logic        err_reg;
    logic [31:0] load_buf_reg;
    logic        bus_ce_reg;
    logic        bus_we_reg;
    logic [31:0] bus_addr_reg;
    logic [3:0]  bus_sel_reg;
    logic [31:0] bus_wdata_reg;

    logic        mem_op;
    logic        misaligned;
    logic        mem_go;
    logic [31:0] load_ext;

    assign mem_op     = is_mem_op(aluop_i);
    assign misaligned = mem_op && is_misaligned(aluop_i, mem_addr_i[1:0]);
    assign mem_go     = mem_op && !misaligned;

    assign bus.bus_ce    = bus_ce_reg;
    assign bus.bus_we    = bus_we_reg;
    assign bus.bus_addr  = bus_addr_reg;
    assign bus.bus_sel   = bus_sel_reg;
    assign bus.bus_wdata = bus_wdata_reg;

    // EX/MEM is frozen while stalled, so aluop_i/addr still describe the load in DONE.
    mem_lane_ext u_lane_ext (
        .aluop (aluop_i),
        .addr  (mem_addr_i[1:0]),
        .word  (load_buf_reg),
        .ext   (load_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 8'h00;
            err_reg       <= 1'b0;
            load_buf_reg  <= ZeroWord;
            bus_ce_reg    <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= ZeroWord;
            bus_sel_reg   <= 4'b0000;
            bus_wdata_reg <= ZeroWord;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mem_go) begin
                        bus_ce_reg    <= 1'b1;
                        bus_we_reg    <= is_store_op(aluop_i);
                        bus_addr_reg  <= {mem_addr_i[31:2], 2'b00};
                        bus_sel_reg   <= lane_sel(aluop_i, mem_addr_i[1:0]);
                        bus_wdata_reg <= is_store_op(aluop_i) ? store_data(aluop_i, reg2_i) : ZeroWord;
                        cnt_reg       <= 8'h00;
                        err_reg       <= 1'b0;
                        state_reg     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // ack takes priority over an expiring timeout on the same edge
                    if (bus.bus_ack) begin
                        load_buf_reg <= bus.bus_rdata;
                        bus_ce_reg   <= 1'b0;
                        bus_we_reg   <= 1'b0;
                        state_reg    <= ST_DONE;
                    end else if (cnt_reg == TIMEOUT_CNT) begin
                        bus_ce_reg <= 1'b0;
                        bus_we_reg <= 1'b0;
                        err_reg    <= 1'b1;
                        state_reg  <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'h01;
                    end
                end
                ST_DONE: begin
                    err_reg   <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wd_o      = wd_i;
        wreg_o    = wreg_i;
        wdata_o   = wdata_i;
        hi_o      = hi_i;
        lo_o      = lo_i;
        whilo_o   = whilo_i;
        stallreq  = 1'b0;
        exc_align = 1'b0;
        exc_bus   = 1'b0;
        if (rst) begin
            wd_o    = NOPRegAddr;
            wreg_o  = 1'b0;
            wdata_o = ZeroWord;
            hi_o    = ZeroWord;
            lo_o    = ZeroWord;
            whilo_o = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (misaligned) begin
                        exc_align = 1'b1;
                        wreg_o    = 1'b0;
                    end else if (mem_go) begin
                        stallreq = 1'b1;
                    end
                end
                ST_WAIT: stallreq = 1'b1;
                ST_DONE: begin
                    if (!is_store_op(aluop_i)) wdata_o = load_ext;
                    if (err_reg) begin
                        exc_bus = 1'b1;
                        wreg_o  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: vector table through a scoreboard, plus
// hand-driven reset sequences.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam logic [7:0] OP_ADDU = 8'b0010_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i, hi_i, lo_i, mem_addr_i, reg2_i;
    logic        whilo_i;
    logic [7:0]  aluop_i;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq, exc_align, exc_bus;
    logic [31:0] wdata_o, hi_o, lo_o;

    mem_lsu_if bif ();

    mem_lsu #(.TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .hi_i(hi_i), .lo_i(lo_i),
        .whilo_i(whilo_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o),
        .whilo_o(whilo_o), .stallreq(stallreq), .exc_align(exc_align), .exc_bus(exc_bus),
        .bus(bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] wdata;
        logic        wreg;
        logic [31:0] rdata;
        int          ack_wait;   // WAIT cycle index that sees ack; -1 = never
        int          exp_stalls;
        logic        exp_ce;
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_bwdata;
        logic [31:0] exp_wdata;
        logic        chk_data;
        logic        exp_wreg;
        logic        exp_align;
        logic        exp_buserr;
    } vec_t;

    typedef struct {
        int          stalls;
        logic        ce;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] bwdata;
        logic [31:0] baddr;
        logic [31:0] wdata;
        logic        chk_data;
        logic        wreg;
        logic        align;
        logic        buserr;
        logic [4:0]  wd;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t        e;
        int          stalls = 0;
        int          waits  = 0;
        logic        saw_ce = 1'b0;
        logic        saw_we = 1'b0;
        logic [3:0]  sel    = 4'b0;
        logic [31:0] bwd    = 32'h0;
        logic [31:0] badr   = 32'h0;
        aluop_i    = v.op;
        mem_addr_i = v.addr;
        reg2_i     = v.reg2;
        wdata_i    = v.wdata;
        wreg_i     = v.wreg;
        wd_i       = 5'(idx + 5);
        hi_i       = 32'hA000_0000 | 32'(idx);
        lo_i       = 32'h0B00_0000 | 32'(idx);
        whilo_i    = idx[0];
        bif.bus_rdata = v.rdata;
        bif.bus_ack   = 1'b0;
        e = '{v.exp_stalls, v.exp_ce, v.exp_we, v.exp_sel, v.exp_bwdata,
              {v.addr[31:2], 2'b00}, v.exp_wdata, v.chk_data, v.exp_wreg,
              v.exp_align, v.exp_buserr, 5'(idx + 5),
              32'hA000_0000 | 32'(idx), 32'h0B00_0000 | 32'(idx), idx[0]};
        sb.push_back(e);
        #1;
        while (stallreq === 1'b1 && stalls < 400) begin
            stalls++;
            if (bif.bus_ce === 1'b1) begin
                if (!saw_ce) begin
                    saw_ce = 1'b1;
                    saw_we = bif.bus_we;
                    sel    = bif.bus_sel;
                    bwd    = bif.bus_wdata;
                    badr   = bif.bus_addr;
                end
                bif.bus_ack = (waits == v.ack_wait);
                waits++;
            end
            @(negedge clk);
            bif.bus_ack = 1'b0;
            #1;
        end
        if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check($sformatf("v%0d_stalls", idx), 32'(stalls), 32'(e.stalls));
            check($sformatf("v%0d_ce_seen", idx), {31'b0, saw_ce}, {31'b0, e.ce});
            if (e.ce) begin
                check($sformatf("v%0d_we", idx), {31'b0, saw_we}, {31'b0, e.we});
                check($sformatf("v%0d_sel", idx), {28'b0, sel}, {28'b0, e.sel});
                check($sformatf("v%0d_addr", idx), badr, e.baddr);
                if (e.we) check($sformatf("v%0d_bwdata", idx), bwd, e.bwdata);
            end
            if (e.chk_data) check($sformatf("v%0d_wdata", idx), wdata_o, e.wdata);
            check($sformatf("v%0d_wreg", idx), {31'b0, wreg_o}, {31'b0, e.wreg});
            check($sformatf("v%0d_wd", idx), {27'b0, wd_o}, {27'b0, e.wd});
            check($sformatf("v%0d_align", idx), {31'b0, exc_align}, {31'b0, e.align});
            check($sformatf("v%0d_buserr", idx), {31'b0, exc_bus}, {31'b0, e.buserr});
            check($sformatf("v%0d_hilo", idx), hi_o ^ lo_o, e.hi ^ e.lo);
            check($sformatf("v%0d_whilo", idx), {31'b0, whilo_o}, {31'b0, e.whilo});
            check($sformatf("v%0d_ce_now", idx), {31'b0, bif.bus_ce}, 32'h0);
            $display("txn %0d op=%h addr=%h stalls=%0d wdata_o=%h wreg_o=%b align=%b buserr=%b",
                     idx, v.op, v.addr, stalls, wdata_o, wreg_o, exc_align, exc_bus);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            op          addr          reg2          wdata         wreg rdata        ackw stl ce we sel      bwdata        exp_wdata     chk wreg al be
        vecs[0]  = '{OP_ADDU,    32'h0000_0000, 32'h0,        32'h1234_5678, 1, 32'h0,        0,   0, 0, 0, 4'b0000, 32'h0,        32'h1234_5678, 1, 1, 0, 0};
        vecs[1]  = '{EXE_LB_OP,  32'h0000_1001, 32'h0,        32'h0,         1, 32'h11F2_3344, 0,  2, 1, 0, 4'b0100, 32'h0,        32'hFFFF_FFF2, 1, 1, 0, 0};
        vecs[2]  = '{EXE_LBU_OP, 32'h0000_1001, 32'h0,        32'h0,         1, 32'h11F2_3344, 0,  2, 1, 0, 4'b0100, 32'h0,        32'h0000_00F2, 1, 1, 0, 0};
        vecs[3]  = '{EXE_SH_OP,  32'h0000_2002, 32'hCAFE_BEEF, 32'h0000_2002, 0, 32'h0,       0,   2, 1, 1, 4'b0011, 32'hBEEF_BEEF, 32'h0000_2002, 1, 0, 0, 0};
        vecs[4]  = '{EXE_LW_OP,  32'h0000_3001, 32'h0,        32'h0,         1, 32'h0,        0,   0, 0, 0, 4'b0000, 32'h0,        32'h0,         0, 0, 1, 0};
        vecs[5]  = '{EXE_LH_OP,  32'h0000_4002, 32'h0,        32'h0,         1, 32'h1234_8765, 2,  4, 1, 0, 4'b0011, 32'h0,        32'hFFFF_8765, 1, 1, 0, 0};
        vecs[6]  = '{EXE_LHU_OP, 32'h0000_4000, 32'h0,        32'h0,         1, 32'h9ABC_0000, 1,  3, 1, 0, 4'b1100, 32'h0,        32'h0000_9ABC, 1, 1, 0, 0};
        vecs[7]  = '{EXE_SB_OP,  32'h0000_5003, 32'h0000_00A5, 32'h0000_5003, 0, 32'h0,       0,   2, 1, 1, 4'b0001, 32'hA5A5_A5A5, 32'h0000_5003, 1, 0, 0, 0};
        vecs[8]  = '{EXE_SW_OP,  32'h0000_6000, 32'hDEAD_BEEF, 32'h0000_6000, 0, 32'h0,       3,   5, 1, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_6000, 1, 0, 0, 0};
        vecs[9]  = '{EXE_LW_OP,  32'h0000_7004, 32'h0,        32'h0,         1, 32'h89AB_CDEF, 0,  2, 1, 0, 4'b1111, 32'h0,        32'h89AB_CDEF, 1, 1, 0, 0};
        vecs[10] = '{EXE_SH_OP,  32'h0000_2001, 32'h1111_2222, 32'h0,        0, 32'h0,        0,   0, 0, 0, 4'b0000, 32'h0,        32'h0,         0, 0, 1, 0};
        vecs[11] = '{EXE_LB_OP,  32'h0000_8000, 32'h0,        32'h0,         1, 32'h8012_3456, 0,  2, 1, 0, 4'b1000, 32'h0,        32'hFFFF_FF80, 1, 1, 0, 0};
        vecs[12] = '{EXE_LB_OP,  32'h0000_8003, 32'h0,        32'h0,         1, 32'h1234_567F, 0,  2, 1, 0, 4'b0001, 32'h0,        32'h0000_007F, 1, 1, 0, 0};
        vecs[13] = '{EXE_LW_OP,  32'h0000_A000, 32'h0,        32'h0,         1, 32'hFFFF_FFFF, -1, 257, 1, 0, 4'b1111, 32'h0,      32'h0,         0, 0, 0, 1};
        vecs[14] = '{EXE_LW_OP,  32'h0000_A004, 32'h0,        32'h0,         1, 32'h0BAD_F00D, 255, 257, 1, 0, 4'b1111, 32'h0,     32'h0BAD_F00D, 1, 1, 0, 0};
        vecs[15] = '{EXE_LHU_OP, 32'h0000_4003, 32'h0,        32'h0,         1, 32'h0,        0,   0, 0, 0, 4'b0000, 32'h0,        32'h0,         0, 0, 1, 0};
        vecs[16] = '{EXE_LBU_OP, 32'h0000_1002, 32'h0,        32'h0,         1, 32'h11F2_3344, 0,  2, 1, 0, 4'b0010, 32'h0,        32'h0000_0033, 1, 1, 0, 0};

        // Reset with a writing op presented: every output must read zero.
        rst = 1'b1;
        aluop_i = OP_ADDU; mem_addr_i = 32'h0; reg2_i = 32'h0; wdata_i = 32'hFFFF_0001;
        wreg_i = 1'b1; wd_i = 5'd7; hi_i = 32'h1; lo_i = 32'h2; whilo_i = 1'b1;
        bif.bus_rdata = 32'h0; bif.bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_wdata", wdata_o, 32'h0);
        check("rst_flags", {26'b0, wd_o == 5'd0 ? 1'b0 : 1'b1, wreg_o, whilo_o, stallreq, exc_align, exc_bus}, 32'h0);
        check("rst_hilo", hi_o | lo_o, 32'h0);
        check("rst_bus", {24'b0, bif.bus_ce, bif.bus_we, 2'b0, bif.bus_sel}, 32'h0);
        check("rst_bus_data", bif.bus_addr | bif.bus_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

        // Reset in the third WAIT cycle of a stalled load.
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h0000_9000; wreg_i = 1'b1; wd_i = 5'd9;
        bif.bus_ack = 1'b0; bif.bus_rdata = 32'h5555_5555;
        #1;
        check("mid_idle_stall", {31'b0, stallreq}, 32'h1);
        repeat (3) @(negedge clk);
        #1;
        check("mid_wait3_ce", {30'b0, bif.bus_ce, stallreq}, 32'h3);
        rst = 1'b1;
        #1;
        check("mid_rst_outs", {28'b0, stallreq, wreg_o, exc_bus, exc_align}, 32'h0);
        check("mid_rst_wdata", wdata_o, 32'h0);
        @(negedge clk);
        #1;
        check("mid_rst_ce", {31'b0, bif.bus_ce}, 32'h0);
        rst = 1'b0;
        aluop_i = OP_ADDU; wdata_i = 32'h0000_0055; wreg_i = 1'b1;
        bif.bus_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("late_ack_c%0d", c), {29'b0, stallreq, bif.bus_ce, exc_bus}, 32'h0);
            check($sformatf("late_ack_wdata_c%0d", c), wdata_o, 32'h0000_0055);
            @(negedge clk);
        end
        bif.bus_ack = 1'b0;
        run_vec(17, '{EXE_LW_OP, 32'h0000_B000, 32'h0, 32'h0, 1, 32'h1357_9BDF, 0, 2, 1, 0,
                      4'b1111, 32'h0, 32'h1357_9BDF, 1, 1, 0, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
